// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the Flappy datapath (pipe RAM, bird physics, score)
// and the game-sequencing controller.
//   master : datapath side, drives bird/pipe/score/flap, consumes controls
//   slave  : flappy_game_ctrl
interface flappy_game_ctrl_if;
  logic       flap;
  logic [9:0] bird_y;
  logic [9:0] pipe_x;
  logic [1:0] pipe_idx;
  logic [9:0] gap_y;
  logic [3:0] score;

  logic       count_EN;
  logic       Lose;
  logic       frame_tick;
  logic       game_rst;
  logic [1:0] state;
  logic       win;
  logic [1:0] hit_pipe;

  modport master (
    output flap, bird_y, pipe_x, pipe_idx, gap_y, score,
    input  count_EN, Lose, frame_tick, game_rst, state, win, hit_pipe
  );

  modport slave (
    input  flap, bird_y, pipe_x, pipe_idx, gap_y, score,
    output count_EN, Lose, frame_tick, game_rst, state, win, hit_pipe
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: round sequencer for the Flappy game.
// Runs the IDLE/PLAY/DYING/OVER round FSM, divides the clock into frame
// ticks, checks bird/pipe/floor collision on each PLAY tick and issues the
// one-cycle game_rst pulse when a finished round is restarted.
// Optional build macro: FLAPPY_CEILING_COLLIDE_EN (ceiling contact is a hit).
//
// state  | meaning
// IDLE   | waiting for a flap edge to start a round
// PLAY   | pipes advance, collision checked every frame tick
// DYING  | bird falls for FALL_FRAMES ticks, Lose asserted
// OVER   | round finished (win or loss), flap edge restarts
module flappy_game_ctrl #(
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned BIRD_X      = 200,
  parameter int unsigned BIRD_W      = 16,
  parameter int unsigned BIRD_H      = 16,
  parameter int unsigned PIPE_W      = 40,
  parameter int unsigned GAP_H       = 120,
  parameter int unsigned FLOOR_Y     = 464,
  parameter int unsigned CEIL_Y      = 0,
  parameter int unsigned FALL_FRAMES = 30,
  parameter int unsigned WIN_SCORE   = 15
) (
  input logic              clk,
  input logic              reset,
  flappy_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // All geometry is compared on 11 bits so sums never wrap.
  localparam logic [10:0] BX_L    = 11'(BIRD_X);
  localparam logic [10:0] BX_R    = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] PW      = 11'(PIPE_W);
  localparam logic [10:0] BH      = 11'(BIRD_H);
  localparam logic [10:0] GH      = 11'(GAP_H);
  localparam logic [10:0] FLOOR_L = 11'(FLOOR_Y);
  localparam logic [10:0] CEIL_L  = 11'(CEIL_Y);
  localparam logic [19:0] DIV_LAST = 20'(TICK_DIV - 1);
  localparam logic [5:0]  DYING_LAST = 6'(FALL_FRAMES - 1);
  localparam logic [4:0]  WIN_L   = 5'(WIN_SCORE);

`ifdef FLAPPY_CEILING_COLLIDE_EN
  localparam logic CEIL_EN = 1'b1;
`else
  localparam logic CEIL_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [19:0] div_q, div_d;
  logic [5:0]  dcnt_q, dcnt_d;
  logic        flap_q, flap_d;
  logic        win_q, win_d;
  logic [1:0]  hit_pipe_q, hit_pipe_d;
  logic        count_en_q, count_en_d;
  logic        lose_q, lose_d;
  logic        tick_q, tick_d;

  logic        flap_edge;
  logic        active;
  logic        h_ov, v_out, floor_hit, ceil_hit, hit;
  logic [10:0] by, px, gy;

  // Collision geometry for the current inputs; only acted on in a PLAY tick.
  always_comb begin
    by        = {1'b0, bus.bird_y};
    px        = {1'b0, bus.pipe_x};
    gy        = {1'b0, bus.gap_y};
    h_ov      = (px < BX_R) && ((px + PW) > BX_L);
    v_out     = (by < gy) || ((by + BH) > (gy + GH));
    floor_hit = (by >= FLOOR_L);
    ceil_hit  = CEIL_EN && (by <= CEIL_L);
    hit       = (h_ov && v_out) || floor_hit || ceil_hit;
  end

  // Next-state, divider, DYING tick counter and registered output decode.
  always_comb begin
    flap_d     = bus.flap;
    flap_edge  = bus.flap & ~flap_q;
    active     = (state_q == ST_PLAY) || (state_q == ST_DYING);
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    win_d      = win_q;
    hit_pipe_d = hit_pipe_q;

    if (active) begin
      div_d = tick_q ? 20'd0 : div_q + 20'd1;
    end else begin
      div_d = 20'd0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (flap_edge) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick_q) begin
          if (hit) begin
            state_d    = ST_DYING;
            hit_pipe_d = bus.pipe_idx;
            win_d      = 1'b0;
            dcnt_d     = 6'd0;
          end else if ({1'b0, bus.score} >= WIN_L) begin
            state_d = ST_OVER;
            win_d   = 1'b1;
          end
        end
      end
      ST_DYING: begin
        if (tick_q) begin
          if (dcnt_q == DYING_LAST) begin
            state_d = ST_OVER;
          end else begin
            dcnt_d = dcnt_q + 6'd1;
          end
        end
      end
      ST_OVER: begin
        if (flap_edge) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The divider is forced to 0 whenever the round is not running, so the
    // tick can only fire in PLAY/DYING.
    tick_d     = (div_d == DIV_LAST);
    count_en_d = (state_d == ST_PLAY);
    lose_d     = (state_d == ST_DYING) || ((state_d == ST_OVER) && !win_d);
  end

  // Round FSM and all its registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= 20'd0;
      dcnt_q     <= 6'd0;
      flap_q     <= 1'b0;
      win_q      <= 1'b0;
      hit_pipe_q <= 2'd0;
      count_en_q <= 1'b0;
      lose_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      dcnt_q     <= dcnt_d;
      flap_q     <= flap_d;
      win_q      <= win_d;
      hit_pipe_q <= hit_pipe_d;
      count_en_q <= count_en_d;
      lose_q     <= lose_d;
      tick_q     <= tick_d;
    end
  end

  // Restart pulse marks the OVER->IDLE cycle itself; reset never pulses it.
  assign bus.game_rst   = (state_q == ST_OVER) && flap_edge && !reset;
  assign bus.count_EN   = count_en_q;
  assign bus.Lose       = lose_q;
  assign bus.frame_tick = tick_q;
  assign bus.state      = state_q;
  assign bus.win        = win_q;
  assign bus.hit_pipe   = hit_pipe_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed round scenarios followed by random
// play, all checked against a round-level reference model.
module tb_flappy_game_ctrl;
  localparam int TD = 4;
  localparam int FF = 3;
  localparam int WS = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  flappy_game_ctrl_if gif();

  flappy_game_ctrl #(
    .TICK_DIV(TD), .FALL_FRAMES(FF), .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(gif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: round mode, cycles since the round started,
  // ticks seen while dying, last flap level and the round result.
  int m_mode = 0;
  int m_act = 0;
  int m_dticks = 0;
  bit m_prev_flap = 0;
  bit m_win = 0;
  int m_hitp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_mode == 1 || m_mode == 2) && (m_act % TD == TD - 1);
  endfunction

  function automatic bit m_hit(int by, int px, int gy);
    bit h_ov, v_out, h;
    h_ov  = (px < 200 + 16) && (px + 40 > 200);
    v_out = (by < gy) || (by + 16 > gy + 120);
    h     = (h_ov && v_out) || (by >= 464);
`ifdef FLAPPY_CEILING_COLLIDE_EN
    h     = h || (by <= 0);
`endif
    return h;
  endfunction

  task automatic model_update();
    bit edge_s, tick_s;
    edge_s = gif.flap && !m_prev_flap;
    tick_s = m_tick();
    if (reset) begin
      m_mode = 0; m_act = 0; m_dticks = 0;
      m_prev_flap = 0; m_win = 0; m_hitp = 0;
      return;
    end
    m_prev_flap = gif.flap;
    case (m_mode)
      0: if (edge_s) begin m_mode = 1; m_act = 0; end
      1: begin
        m_act++;
        if (tick_s) begin
          if (m_hit(int'(gif.bird_y), int'(gif.pipe_x), int'(gif.gap_y))) begin
            m_mode = 2; m_hitp = int'(gif.pipe_idx); m_win = 0; m_dticks = 0;
          end else if (int'(gif.score) >= WS) begin
            m_mode = 3; m_win = 1;
          end
        end
      end
      2: begin
        m_act++;
        if (tick_s) begin
          m_dticks++;
          if (m_dticks == FF) m_mode = 3;
        end
      end
      default: if (edge_s) m_mode = 0;
    endcase
  endtask

  task automatic check_model();
    chk("state", 32'(gif.state), 32'(m_mode));
    chk("count_EN", 32'(gif.count_EN), 32'(m_mode == 1));
    chk("Lose", 32'(gif.Lose), 32'(m_mode == 2 || (m_mode == 3 && !m_win)));
    chk("frame_tick", 32'(gif.frame_tick), 32'(m_tick()));
    chk("game_rst", 32'(gif.game_rst),
        32'(m_mode == 3 && gif.flap && !m_prev_flap && !reset));
    chk("win", 32'(gif.win), 32'(m_win));
    chk("hit_pipe", 32'(gif.hit_pipe), 32'(m_hitp));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic go_play();
    reset = 1'b1; step();
    reset = 1'b0; gif.flap = 1'b0; step();
    gif.flap = 1'b1; step();
  endtask

  int n;
  int ticks;

  initial begin
    gif.flap = 1'b0; gif.bird_y = 10'd200; gif.pipe_x = 10'd400;
    gif.pipe_idx = 2'd0; gif.gap_y = 10'd150; gif.score = 4'd0;

    // Reset for two cycles.
    @(negedge clk);
    step(); step();
    chk("reset_state", 32'(gif.state), 32'd0);
    chk("reset_tick", 32'(gif.frame_tick), 32'd0);

    // Start and tick period.
    reset = 1'b0; step();
    gif.flap = 1'b1; step();
    chk("start_state", 32'(gif.state), 32'd1);
    chk("start_count_EN", 32'(gif.count_EN), 32'd1);
    ticks = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      step();
      if (gif.frame_tick) ticks++;
    end
    chk("tick_period", 32'(ticks), 32'd2);

    // Pipe collision and dying duration.
    gif.pipe_x = 10'd190; gif.bird_y = 10'd100; gif.gap_y = 10'd150; gif.pipe_idx = 2'd2;
    n = 0;
    while (gif.state == 2'd1 && n < 10) begin step(); n++; end
    chk("collide_state", 32'(gif.state), 32'd2);
    chk("collide_Lose", 32'(gif.Lose), 32'd1);
    chk("collide_count_EN", 32'(gif.count_EN), 32'd0);
    chk("collide_hit_pipe", 32'(gif.hit_pipe), 32'd2);
    n = 0;
    while (gif.state == 2'd2 && n < 30) begin step(); n++; end
    chk("dying_len", 32'(n), 32'(FF * TD));
    chk("over_state", 32'(gif.state), 32'd3);

    // Restart from OVER.
    gif.flap = 1'b0; step();
    gif.flap = 1'b1; #1;
    chk("restart_game_rst", 32'(gif.game_rst), 32'd1);
    step();
    chk("restart_state", 32'(gif.state), 32'd0);
    chk("restart_pulse_end", 32'(gif.game_rst), 32'd0);

    // Safe pass, then win.
    gif.flap = 1'b0; step();
    gif.flap = 1'b1; step();
    gif.pipe_x = 10'd190; gif.bird_y = 10'd200; gif.gap_y = 10'd150; gif.score = 4'd0;
    for (int i = 0; i < TD; i++) step();
    chk("safe_pass", 32'(gif.state), 32'd1);
    gif.score = 4'd15;
    n = 0;
    while (gif.state == 2'd1 && n < 10) begin step(); n++; end
    chk("win_state", 32'(gif.state), 32'd3);
    chk("win_flag", 32'(gif.win), 32'd1);
    chk("win_Lose", 32'(gif.Lose), 32'd0);

    // Tie-break: floor hit and winning score on the same tick.
    gif.flap = 1'b0; step();
    gif.flap = 1'b1; step();
    gif.flap = 1'b0; step();
    gif.flap = 1'b1; step();
    gif.bird_y = 10'd470;
    n = 0;
    while (gif.state == 2'd1 && n < 10) begin step(); n++; end
    chk("tie_state", 32'(gif.state), 32'd2);

    // Ceiling contact, then reset while dying.
    go_play();
    gif.score = 4'd0; gif.pipe_x = 10'd400; gif.bird_y = 10'd0; gif.gap_y = 10'd150;
    for (int i = 0; i < TD; i++) step();
`ifdef FLAPPY_CEILING_COLLIDE_EN
    chk("ceiling", 32'(gif.state), 32'd2);
`else
    chk("ceiling", 32'(gif.state), 32'd1);
`endif
    gif.bird_y = 10'd470;
    n = 0;
    while (gif.state == 2'd1 && n < 10) begin step(); n++; end
    chk("pre_reset_dying", 32'(gif.state), 32'd2);
    reset = 1'b1; step();
    chk("reset_in_dying", 32'(gif.state), 32'd0);
    reset = 1'b0;

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) gif.flap = ~gif.flap;
      case ($urandom_range(0, 9))
        0: gif.bird_y = 10'd470;
        1: gif.bird_y = 10'd0;
        default: gif.bird_y = 10'($urandom_range(100, 300));
      endcase
      gif.pipe_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(150, 250))
                                               : 10'($urandom_range(300, 600));
      gif.gap_y = 10'($urandom_range(80, 200));
      gif.score = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      gif.pipe_idx = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-sequencing controller for the Flappy datapath. Owns the round state machine (idle, play, dying, over), holds the pipe X-position RAM's `count_EN` during play, and generates the frame tick that drives bird physics. Each frame it checks bird/pipe collision and floor contact and asserts `Lose` to the pipe RAM and the score logic. It also issues the one-cycle `game_rst` pulse that restarts the pipe RAM between rounds.

## Interface
- `TICK_DIV`, 833333: clock cycles per frame tick (60 Hz at 50 MHz); legal range 2..2^20.
- `BIRD_X`, 200: fixed left edge of the bird, in pixels.
- `BIRD_W`, 16: bird width, in pixels.
- `BIRD_H`, 16: bird height, in pixels.
- `PIPE_W`, 40: pipe width, in pixels.
- `GAP_H`, 120: vertical gap height, in pixels.
- `FLOOR_Y`, 464: bird_y at or above this value is a floor hit.
- `CEIL_Y`, 0: ceiling line (used only with the macro).
- `FALL_FRAMES`, 30: frame ticks spent in DYING.
- `WIN_SCORE`, 15: score that ends the round as a win.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flap` in 1: button level, already debounced.
- `bird_y` in 10: bird top edge, in pixels.
- `pipe_x` in 10: current pipe left edge (pipe RAM `Output`).
- `pipe_idx` in 2: current pipe number (pipe RAM `out_pipe`); informational, latched only.
- `gap_y` in 10: gap top edge for the current pipe.
- `score` in 4: score from the pipe RAM (`Score`).
- `count_EN` out 1: pipe RAM advance enable.
- `Lose` out 1: round lost.
- `frame_tick` out 1: one-cycle frame strobe.
- `game_rst` out 1: one-cycle restart pulse for the pipe RAM and bird.
- `state` out 2: IDLE=0, PLAY=1, DYING=2, OVER=3.
- `win` out 1: last round ended by reaching WIN_SCORE.
- `hit_pipe` out 2: `pipe_idx` latched at the collision.

## Operation
- **Flap edge:** `flap_q` is registered, and `flap_edge = flap & ~flap_q`.
- **Frame divider:** counts 0..TICK_DIV-1 in PLAY and DYING only.
  - `frame_tick` is high for the one cycle where count == TICK_DIV-1, after which the divider wraps to 0.
  - The divider is held at 0 in IDLE and OVER.
- **Collision**, evaluated only when `frame_tick` is high in PLAY. All sums are zero-extended to 11 bits; there is no wrap.
  - `h_ov = (pipe_x < BIRD_X+BIRD_W) && (pipe_x+PIPE_W > BIRD_X)`.
  - `v_out = (bird_y < gap_y) || (bird_y+BIRD_H > gap_y+GAP_H)`.
  - `hit = (h_ov && v_out) || (bird_y >= FLOOR_Y)`.
- **FSM transitions:**
  - IDLE -> PLAY on `flap_edge`.
  - PLAY -> DYING on a tick with `hit`; `hit_pipe` <= `pipe_idx` and `win` <= 0.
  - PLAY -> OVER on a tick with `!hit` and `score >= WIN_SCORE`; `win` <= 1.
  - DYING -> OVER after the FALL_FRAMES-th tick counted in DYING (6-bit tick counter, cleared on DYING entry).
  - OVER -> IDLE on `flap_edge`, with `game_rst` = 1 for exactly that cycle.
- **Moore outputs**, decoded from the state register:
  - `count_EN` = (state == PLAY).
  - `Lose` = (state == DYING) || (state == OVER && !win).
- **Hold rules:**
  - `flap_edge` in PLAY or DYING is ignored by the FSM.
  - `win` and `hit_pipe` hold their values until the next PLAY->DYING or PLAY->OVER transition, or until reset.

## Timing
- **Reset values:**
  - State machine, counters and `flap_q`: state = IDLE, divider = 0, DYING tick counter = 0, `flap_q` = 0.
  - All outputs 0: `count_EN`, `Lose`, `frame_tick`, `game_rst`, `win`, `hit_pipe`.
- **Reset mid-round:** reset in any state forces IDLE on the same edge and overrides every other condition. `game_rst` is not pulsed by reset.
- **Latencies:**
  - flap rise at edge N: `flap_edge` is seen in cycle N; the state changes at edge N+1, so `count_EN` rises 1 cycle after the flap is sampled.
  - Collision on tick cycle T: `Lose` is high and `count_EN` low from T+1.
  - First `frame_tick` comes TICK_DIV cycles after PLAY entry.
- **Simultaneous events:** hit and `score >= WIN_SCORE` on the same tick gives DYING (the loss wins).
- **DYING duration:** exactly FALL_FRAMES*TICK_DIV cycles.
- **Input sampling:** inputs are sampled only in the tick cycle. Inputs must be stable from the tick cycle through the following edge; no internal synchronizers are provided.

## Configuration
- **`FLAPPY_CEILING_COLLIDE_EN`**
  - Defined: `hit` additionally includes `bird_y <= CEIL_Y`, so hitting the ceiling kills the bird.
  - Undefined: the ceiling is never a hit; bird clamping is left to the physics block.
  - The port list is identical in both builds.

## Test plan
All scenarios use TICK_DIV=4, FALL_FRAMES=3, WIN_SCORE=15.
- **Reset:** reset high for 2 cycles -> `state`=0, `count_EN`=0, `Lose`=0, no `frame_tick`.
- **Start and tick period:** flap 0->1 in IDLE -> `state`=1 and `count_EN`=1 one cycle later; `frame_tick` every 4 cycles.
- **Pipe collision:** `pipe_x`=190, `bird_y`=100, `gap_y`=150 at a tick -> next cycle `state`=2, `Lose`=1, `count_EN`=0, `hit_pipe`=`pipe_idx`; `state`=3 exactly 12 cycles later.
- **Safe pass, then win:**
  - `pipe_x`=190, `bird_y`=200, `gap_y`=150 -> stays PLAY.
  - `score`=15 at the next tick -> `state`=3, `win`=1, `Lose`=0.
- **Tie-break and restart:**
  - `bird_y`=470 with `score`=15 on the same tick -> DYING.
  - In OVER, a flap edge -> `game_rst`=1 for one cycle, then `state`=0.
- **Macro and reset mid-round:**
  - With the macro, `bird_y`=0 in PLAY -> DYING; without the macro -> stays PLAY.
  - Reset asserted in DYING -> IDLE on the next edge.
